// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, refresh FSM states and address constants shared by the refresh slice.
package sdram_pkg;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam int A10 = 10;
  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_TRP, ST_AREF, ST_TRFC, ST_DONE} ref_state_e;
endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer: refresh interval timer and saturating credit counter with sticky overflow.
module sdram_ref_timer #(
  parameter int REF_INTERVAL = 750,
  parameter int MAX_PEND     = 8,
  parameter int PW           = $clog2(MAX_PEND + 1)
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic          en_i,
  input  logic          dec_i,
  output logic [PW-1:0] pend_cnt_o,
  output logic          ovf_o
);
  localparam int TW = REF_INTERVAL > 1 ? $clog2(REF_INTERVAL) : 1;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          tick, full;
  always_comb begin
    tick    = en_i && (timer_q == TW'(REF_INTERVAL - 1));
    full    = pend_q == PW'(MAX_PEND);
    timer_d = (!en_i || tick) ? '0 : timer_q + 1'b1;
    // a tick and an AREF in the same cycle cancel out
    pend_d  = !en_i                            ? '0 :
              (tick && !dec_i && !full)        ? pend_q + 1'b1 :
              (!tick && dec_i && pend_q != '0) ? pend_q - 1'b1 : pend_q;
    ovf_d   = ovf_q || (tick && !dec_i && full);
  end
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end
  assign pend_cnt_o = pend_q;
  assign ovf_o      = ovf_q;
endmodule

// File: rtl/sdram_aref_ctrl.sv
// sdram_aref_ctrl: SDRAM auto-refresh controller issuing PRE-all plus a burst of AREFs per arbiter grant.
module sdram_aref_ctrl
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 750,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int MAX_PEND     = 8,
  parameter int BURST_MAX    = 4,
  parameter int ADDR_W       = 12
) (
  input  logic                             sclk,
  input  logic                             s_rst_n,
  input  logic                             flag_init_end,
  input  logic                             ref_en,
  output logic                             ref_req,
  output logic                             ref_urgent,
  output logic                             flag_ref_end,
  output logic                             ref_busy,
  output logic                             ref_ovf,
  output logic [$clog2(MAX_PEND+1)-1:0]    pend_cnt,
  output logic [3:0]                       aref_cmd,
  output logic [ADDR_W-1:0]                sdram_addr
);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int NW = $clog2(BURST_MAX + 1);
  localparam int CW = $clog2((T_RP > T_RFC ? T_RP : T_RFC) + 1);
  // wait counters count down to zero; the PRE/AREF cycle itself is the first cycle of each gap
  localparam logic [CW-1:0] TRP_LD  = T_RP > 1 ? CW'(T_RP - 2) : '0;
  localparam logic [CW-1:0] TRFC_LD = T_RFC > 1 ? CW'(T_RFC - 2) : '0;
  ref_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] n_q, n_d;
  logic          grant;
  sdram_ref_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .MAX_PEND    (MAX_PEND),
    .PW          (PW)
  ) u_timer (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .en_i      (flag_init_end),
    .dec_i     (state_q == ST_AREF),
    .pend_cnt_o(pend_cnt),
    .ovf_o     (ref_ovf)
  );
  assign ref_req      = (state_q == ST_IDLE) && (pend_cnt != '0);
  assign ref_urgent   = pend_cnt == PW'(MAX_PEND);
  assign flag_ref_end = state_q == ST_DONE;
  assign ref_busy     = state_q != ST_IDLE;
  assign grant        = ref_req && ref_en;
  assign aref_cmd     = state_q == ST_PRE  ? CMD_PRE  :
                        state_q == ST_AREF ? CMD_AREF : CMD_NOP;
  assign sdram_addr   = ADDR_W'(1) << A10;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    unique case (state_q)
      ST_IDLE: if (grant) begin
        state_d = ST_PRE;
        n_d     = pend_cnt > PW'(BURST_MAX) ? NW'(BURST_MAX) : NW'(pend_cnt);
      end
      ST_PRE: begin
        state_d = T_RP > 1 ? ST_TRP : ST_AREF;
        cnt_d   = TRP_LD;
      end
      ST_TRP: begin
        state_d = cnt_q == '0 ? ST_AREF : ST_TRP;
        cnt_d   = cnt_q - 1'b1;
      end
      ST_AREF: begin
        n_d     = n_q - 1'b1;
        cnt_d   = TRFC_LD;
        state_d = T_RFC > 1 ? ST_TRFC : (n_q > NW'(1) ? ST_AREF : ST_DONE);
      end
      ST_TRFC: begin
        state_d = cnt_q != '0 ? ST_TRFC : (n_q != '0 ? ST_AREF : ST_DONE);
        cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end
endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// tb_sdram_aref_ctrl: directed stimulus with an offset-based behavioural model checked every cycle.
module tb_sdram_aref_ctrl;
  localparam int RI = 20, TRP = 2, TRFC = 7, MP = 4, BM = 2;
  localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, AREF = 4'b0001;
  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        flag_init_end = 1'b0;
  logic        ref_en = 1'b0;
  logic        ref_req, ref_urgent, flag_ref_end, ref_busy, ref_ovf;
  logic [2:0]  pend_cnt;
  logic [3:0]  aref_cmd;
  logic [11:0] sdram_addr;
  int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0;
  int m_timer = 0, m_pend = 0, m_start = 0, m_n = 0, mo = 0;
  bit m_ovf = 0, m_busy = 0, mt = 0, ma = 0, mg = 0, mf = 0;

  sdram_aref_ctrl #(.REF_INTERVAL(RI), .T_RP(TRP), .T_RFC(TRFC), .MAX_PEND(MP),
                    .BURST_MAX(BM), .ADDR_W(12)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end), .ref_en(ref_en),
    .ref_req(ref_req), .ref_urgent(ref_urgent), .flag_ref_end(flag_ref_end),
    .ref_busy(ref_busy), .ref_ovf(ref_ovf), .pend_cnt(pend_cnt),
    .aref_cmd(aref_cmd), .sdram_addr(sdram_addr));

  always #5 sclk = ~sclk;

  // Command expected at offset 'off' from the PRE of a burst of n refreshes
  function automatic logic [3:0] f_cmd(input int off, input int n);
    if (off == 0) return PRE;
    if (off >= TRP && (off - TRP) % TRFC == 0 && (off - TRP) / TRFC < n) return AREF;
    return NOP;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge sclk);
  endtask

  task automatic pulse_en(input int c);
    at(c);
    #1 ref_en = 1'b1;
    at(c + 1);
    #1 ref_en = 1'b0;
  endtask

  always @(posedge sclk) cyc <= cyc + 1;

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      m_timer = 0; m_pend = 0; m_ovf = 0; m_busy = 0;
    end else begin
      mo = cyc - m_start;
      ma = m_busy && f_cmd(mo, m_n) == AREF;
      mf = m_busy && mo == TRP + m_n * TRFC;
      mg = ref_en && !m_busy && m_pend != 0;
      if (mg) begin
        m_n = m_pend < BM ? m_pend : BM;
        m_start = cyc + 1;
        m_busy = 1;
      end
      if (mf) m_busy = 0;
      mt = flag_init_end && m_timer == RI - 1;
      if (!flag_init_end) begin
        m_timer = 0; m_pend = 0;
      end else begin
        m_timer = mt ? 0 : m_timer + 1;
        if (mt && !ma) begin
          if (m_pend == MP) m_ovf = 1; else m_pend++;
        end else if (!mt && ma && m_pend > 0) m_pend--;
      end
    end
  end

  always @(negedge sclk) begin
    chk("cmd", 32'(aref_cmd), 32'(m_busy ? f_cmd(cyc - m_start, m_n) : NOP));
    chk("end", 32'(flag_ref_end), 32'(m_busy && (cyc - m_start) == TRP + m_n * TRFC));
    chk("busy", 32'(ref_busy), 32'(m_busy));
    chk("req", 32'(ref_req), 32'(!m_busy && m_pend != 0));
    chk("urgent", 32'(ref_urgent), 32'(m_pend == MP));
    chk("ovf", 32'(ref_ovf), 32'(m_ovf));
    chk("pend", 32'(pend_cnt), 32'(m_pend));
    chk("addr", 32'(sdram_addr), 32'h400);
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge sclk);
    #1 s_rst_n = 1'b1;
    at(cyc + 100);
    chk("t1_cmd", 32'(aref_cmd), 32'h7);
    chk("t1_req", 32'(ref_req), 32'h0);
    chk("t1_pend", 32'(pend_cnt), 32'h0);
    chk("t1_addr", 32'(sdram_addr), 32'h400);
    t0 = cyc + 1;
    at(t0);
    #1 flag_init_end = 1'b1;
    at(t0 + 19); chk("t2_pend19", 32'(pend_cnt), 0);
    at(t0 + 20); chk("t2_pend20", 32'(pend_cnt), 1); chk("t2_req20", 32'(ref_req), 1);
    pulse_en(t0 + 22);
    at(t0 + 23); chk("t2_pre", 32'(aref_cmd), 32'(PRE)); chk("t2_busy23", 32'(ref_busy), 1);
    at(t0 + 25); chk("t2_aref", 32'(aref_cmd), 32'(AREF));
    at(t0 + 26); chk("t2_pend26", 32'(pend_cnt), 0);
    at(t0 + 32); chk("t2_end", 32'(flag_ref_end), 1); chk("t2_busy32", 32'(ref_busy), 1);
    at(t0 + 33); chk("t2_busy33", 32'(ref_busy), 0);
    at(t0 + 99); chk("t3_pend99", 32'(pend_cnt), 3); chk("t3_urg99", 32'(ref_urgent), 0);
    at(t0 + 100); chk("t3_pend", 32'(pend_cnt), 4); chk("t3_urg", 32'(ref_urgent), 1);
    chk("t3_ovf0", 32'(ref_ovf), 0);
    at(t0 + 120); chk("t3_ovf", 32'(ref_ovf), 1); chk("t3_sat", 32'(pend_cnt), 4);
    pulse_en(t0 + 121);
    at(t0 + 138); chk("t4a_end", 32'(flag_ref_end), 1); chk("t4a_pend", 32'(pend_cnt), 2);
    at(t0 + 140); chk("t4_pend3", 32'(pend_cnt), 3);
    pulse_en(t0 + 140);
    at(t0 + 141); chk("t4_pre", 32'(aref_cmd), 32'(PRE));
    at(t0 + 143); chk("t4_aref1", 32'(aref_cmd), 32'(AREF));
    at(t0 + 150); chk("t4_aref2", 32'(aref_cmd), 32'(AREF));
    at(t0 + 157); chk("t4_end", 32'(flag_ref_end), 1);
    at(t0 + 158); chk("t4_pend", 32'(pend_cnt), 1); chk("t4_req", 32'(ref_req), 1);
    pulse_en(t0 + 176);
    at(t0 + 179); chk("t5_aref_tick", 32'(aref_cmd), 32'(AREF));
    at(t0 + 180); chk("t5_pend_same", 32'(pend_cnt), 2);
    pulse_en(t0 + 182);
    at(t0 + 183); chk("t5_nopre", 32'(aref_cmd), 32'(NOP));
    at(t0 + 186); chk("t5_aref2", 32'(aref_cmd), 32'(AREF));
    at(t0 + 187); chk("t5_pend", 32'(pend_cnt), 1);
    at(t0 + 193); chk("t5_end", 32'(flag_ref_end), 1);
    at(t0 + 194); chk("t5_req", 32'(ref_req), 1);
    pulse_en(t0 + 200);
    at(t0 + 201); chk("t6_pre", 32'(aref_cmd), 32'(PRE));
    at(t0 + 202);
    #1 s_rst_n = 1'b0;
    #1 chk("t6_cmd", 32'(aref_cmd), 32'(NOP)); chk("t6_pend", 32'(pend_cnt), 0);
    chk("t6_busy", 32'(ref_busy), 0); chk("t6_ovf", 32'(ref_ovf), 0);
    at(t0 + 203); chk("t6_noaref", 32'(aref_cmd), 32'(NOP));
    at(t0 + 205);
    #1 s_rst_n = 1'b1;
    at(t0 + 225); chk("t7_pend", 32'(pend_cnt), 1);
    pulse_en(t0 + 226);
    at(t0 + 228);
    #1 flag_init_end = 1'b0;
    at(t0 + 229); chk("t7_aref", 32'(aref_cmd), 32'(AREF));
    at(t0 + 230); chk("t7_pend0", 32'(pend_cnt), 0);
    at(t0 + 236); chk("t7_end", 32'(flag_ref_end), 1);
    at(t0 + 260); chk("t7_idle", 32'(ref_busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_aref_ctrl.md
Name: sdram_aref_ctrl

Overview:
Parametrised SDRAM auto-refresh controller with postponed-refresh credit accounting and multi-command refresh bursts. A periodic interval timer accrues refresh credits after initialisation completes. On grant from the arbiter, the block issues one precharge-all followed by up to BURST_MAX auto-refresh commands, honouring tRP and tRFC. It sits between the init block and the command arbiter and drives a command/address slot on the arbiter's mux.

Parameters:
REF_INTERVAL, 750, cycles per refresh credit (tREFI / tCLK)
T_RP, 2, cycles from PRE to first AREF (≥1)
T_RFC, 7, cycles from AREF to next AREF or to end (≥1)
MAX_PEND, 8, credit counter saturation value (≥1)
BURST_MAX, 4, max AREFs per grant (1..MAX_PEND)
ADDR_W, 12, SDRAM address width (≥11)

Ports:
sclk  in  1  system clock
s_rst_n  in  1  asynchronous active-low reset
flag_init_end  in  1  init done; level, enables timer
ref_en  in  1  arbiter grant, single-cycle
ref_req  out  1  refresh request to arbiter
ref_urgent  out  1  pend_cnt == MAX_PEND; arbiter must preempt
flag_ref_end  out  1  one-cycle pulse, refresh sequence finished
ref_busy  out  1  sequence in progress
ref_ovf  out  1  sticky: credit lost at saturation
pend_cnt  out  $clog2(MAX_PEND+1)  outstanding credits
aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
sdram_addr  out  ADDR_W  bit 10 = 1, all other bits 0 (precharge-all)

Behaviour:
- One clock; reset is asynchronous and active-low; ports named sclk / s_rst_n.
- Reset values: aref_cmd = NOP (4'b0111), ref_req/ref_urgent/flag_ref_end/ref_busy/ref_ovf = 0, pend_cnt = 0, FSM = IDLE, timer = 0. sdram_addr is constant.
- Encodings: NOP 4'b0111, PRE 4'b0010, AREF 4'b0001.
- Timer:
  - While flag_init_end = 0: timer holds 0 and pend_cnt holds 0.
  - Otherwise counts 0..REF_INTERVAL-1; the tick is the cycle the count equals REF_INTERVAL-1, then it wraps to 0.
- Credits:
  - Tick increments pend_cnt; each AREF issue cycle decrements it.
  - Tick and AREF in the same cycle: net unchanged.
  - Tick at MAX_PEND with no AREF: pend_cnt stays MAX_PEND and ref_ovf sets, sticky until reset.
- ref_req = (FSM == IDLE) && (pend_cnt != 0), decoded from registers.
- ref_urgent = (pend_cnt == MAX_PEND).
- ref_en is honoured only when ref_req = 1. Otherwise it is ignored.
- FSM states: IDLE, PRE, TRP, AREF, TRFC, DONE.
  - IDLE → PRE on accepted grant. Latch n = min(pend_cnt, BURST_MAX).
  - PRE: aref_cmd = PRE for 1 cycle (grant cycle + 1). → TRP.
  - TRP: NOP; wait so that AREF occurs exactly T_RP cycles after PRE. → AREF.
  - AREF: aref_cmd = AREF for 1 cycle; decrement n. → TRFC.
  - TRFC: NOP for T_RFC-1 cycles. Then → AREF if n > 0, else → DONE.
  - DONE: flag_ref_end = 1 for 1 cycle, T_RFC cycles after the last AREF. → IDLE.
- aref_cmd = NOP in every non-PRE/AREF cycle.
- ref_busy = 1 from the PRE cycle through the DONE cycle inclusive.
- ref_req re-asserts in the cycle after DONE if credits remain.
- Reset mid-sequence: immediate NOP, all state cleared, credits lost.
- flag_init_end falling mid-sequence: the sequence completes; credits are then cleared.

Decomposition:
- Shared package sdram_pkg: command encodings (CMD_NOP/PRE/AREF), FSM state enum, A10 bit index constant.
- Sub-module sdram_ref_timer: interval counter, credit counter, saturation and ovf logic.
- Parent holds the FSM and outputs.

Test Plan:
All tests use REF_INTERVAL=20, T_RP=2, T_RFC=7, MAX_PEND=4, BURST_MAX=2.
1. Reset, flag_init_end=0 for 100 cycles → aref_cmd=4'b0111, ref_req=0, pend_cnt=0, sdram_addr=12'h400.
2. flag_init_end=1 at cycle 0 → tick at 19, pend_cnt=1 and ref_req=1 at 20. ref_en at 22 → PRE at 23, AREF at 25, pend_cnt=0 at 26, flag_ref_end at 32, ref_busy high 23..32.
3. No grants for 5 intervals → pend_cnt=4 and ref_urgent=1 after 4th tick. 5th tick → ref_ovf=1, pend_cnt stays 4.
4. pend_cnt=3, grant → PRE at P, AREF at P+2 and P+9, flag_ref_end at P+16, pend_cnt=1, ref_req=1 at P+17.
5. Tick coincident with an AREF cycle → pend_cnt unchanged that cycle. ref_en while busy → ignored, no extra PRE.
6. Assert s_rst_n=0 on the cycle after PRE → aref_cmd=NOP immediately, pend_cnt=0, no AREF issued.
